// File: rtl/sam_memory_responder.sv
// Purpose: memory-side slave for the SAM CPU REQUEST/RW/WAIT handshake, backed by a word array.
// Latency: mem_wait is high for WAIT_CYCLES+1 cycles; data_out/err are valid in the first DONE cycle.
// Backpressure: mem_wait holds the CPU until the access is done; dropping request before then aborts the access.
//
// Ports: clk, rst_n (async, active low); address/request/rw/data_in from the CPU (MAR/MBR);
//        data_out (registered read data), mem_wait (access still pending), err (access fault).
// Optional feature: define SAM_MEM_ALIGN_CHECK_EN to flag misaligned and out-of-range accesses on err.
//        When it is left undefined, err is tied low, addresses wrap modulo DEPTH_WORDS and address[0] is ignored.
module sam_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic        request,
    input  logic        rw,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        mem_wait,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic [15:0] wdat_q;
    logic        rw_q;

    logic [15:0] mem [DEPTH_WORDS];

    logic          do_acc;
    logic [15:0]   acc_addr;
    logic [15:0]   acc_wdat;
    logic          acc_rw;
    logic          acc_fault;
    logic [AW-1:0] acc_idx;
    logic          mem_we;
    logic          unused_addr_bits;

    // Next state. With zero wait states the access happens in IDLE, so it must
    // use the live inputs because nothing has been latched yet.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        do_acc   = 1'b0;
        acc_addr = addr_q;
        acc_rw   = rw_q;
        acc_wdat = wdat_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    if (WAIT_CYCLES == 0) begin
                        do_acc   = 1'b1;
                        acc_addr = address;
                        acc_rw   = rw;
                        acc_wdat = data_in;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Abort has priority over completion, including at cnt == 0.
                if (!request) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_acc  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_idx          = acc_addr[AW:1];
    assign unused_addr_bits = ^acc_addr;

`ifdef SAM_MEM_ALIGN_CHECK_EN
    localparam logic [16:0] ADDR_LIMIT = 17'(2 * DEPTH_WORDS);
    assign acc_fault = acc_addr[0] || ({1'b0, acc_addr} >= ADDR_LIMIT);
`else
    assign acc_fault = 1'b0;
`endif

    // The array has no reset, so gate writes with rst_n to drop a pending write
    // when reset lands in the same cycle.
    assign mem_we = rst_n && do_acc && !acc_rw && !acc_fault;

    // Decoded from registered state, so it rises combinationally with request.
    assign mem_wait = rst_n && request && (state_q != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'd0;
            wdat_q   <= 16'd0;
            rw_q     <= 1'b0;
            data_out <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && request) begin
                addr_q <= address;
                rw_q   <= rw;
                wdat_q <= data_in;
            end
            if (do_acc && acc_rw) begin
                data_out <= acc_fault ? 16'd0 : mem[acc_idx];
            end
        end
    end

`ifdef SAM_MEM_ALIGN_CHECK_EN
    // err tracks the most recent completed access; aborted accesses leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (do_acc) begin
            err <= acc_fault;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdat;
        end
    end

endmodule

// File: tb/tb_sam_memory_responder.sv
// Purpose: scoreboard bench for sam_memory_responder with a 3-wait-state instance (A) and a 0-wait-state instance (B).
// Latency: each completion is checked for data_out, err and the number of cycles mem_wait was high.
// Backpressure: the driver holds request until mem_wait falls, then drops it for one cycle.
module tb_sam_memory_responder;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;
    logic        req_a, rw_a, wait_a, err_a;
    logic        req_b, rw_b, wait_b, err_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   lat_a    = 0;
    int   lat_b    = 0;

`ifdef SAM_MEM_ALIGN_CHECK_EN
    localparam logic [15:0] LAST_RD = 16'hBEEF;
`else
    localparam logic [15:0] LAST_RD = 16'h4321;
`endif

    sam_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .address(addr_a), .request(req_a), .rw(rw_a),
        .data_in(din_a), .data_out(dout_a), .mem_wait(wait_a), .err(err_a)
    );

    sam_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .address(addr_b), .request(req_b), .rw(rw_b),
        .data_in(din_b), .data_out(dout_b), .mem_wait(wait_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drive(input int s, input logic q, input logic [15:0] a, input logic r, input logic [15:0] d);
        if (s == 0) begin
            req_a = q; addr_a = a; rw_a = r; din_a = d;
        end else begin
            req_b = q; addr_b = a; rw_b = r; din_b = d;
        end
    endtask

    function automatic logic wait_of(input int s);
        return (s == 0) ? wait_a : wait_b;
    endfunction

    // One complete access. a2/d2 are applied one cycle after request rises
    // and must be ignored by the DUT.
    task automatic acc(input int s, input logic [15:0] a, input logic r, input logic [15:0] d,
                       input logic [15:0] a2, input logic [15:0] d2,
                       input logic [15:0] ed, input logic ee);
        exp_t x;
        logic got;
        x.d   = ed;
        x.e   = ee;
        x.lat = (s == 0) ? 8'd4 : 8'd1;
        if (s == 0) qa.push_back(x); else qb.push_back(x);
        @(posedge clk); #1;
        drive(s, 1'b1, a, r, d);
        @(posedge clk); #1;
        drive(s, 1'b1, a2, r, d2);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wait_of(s)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL timeout_dut%0d addr=%h actual=wait_high required=wait_low", s, a);
        end
        @(posedge clk); #1;
        drive(s, 1'b0, a2, r, d2);
    endtask

    // Write whose request is dropped after n cycles, while still in BUSY.
    task automatic abort_wr(input logic [15:0] a, input logic [15:0] d, input int n);
        @(posedge clk); #1;
        drive(0, 1'b1, a, 1'b0, d);
        repeat (n) @(posedge clk);
        #1;
        drive(0, 1'b0, a, 1'b0, d);
    endtask

    // Monitors: a completion is the first cycle with request high and mem_wait low
    // after mem_wait was high.
    always @(negedge clk) begin
        if (!rst_n || !req_a) begin
            lat_a = 0;
        end else if (wait_a) begin
            lat_a++;
        end else if (lat_a != 0) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_done actual=completion required=none");
            end else begin
                exp_t x;
                x = qa.pop_front();
                cmp("a_data_out", {16'd0, dout_a}, {16'd0, x.d});
                cmp("a_err", {31'd0, err_a}, {31'd0, x.e});
                cmp("a_wait_cycles", lat_a, {24'd0, x.lat});
            end
            lat_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n || !req_b) begin
            lat_b = 0;
        end else if (wait_b) begin
            lat_b++;
        end else if (lat_b != 0) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done actual=completion required=none");
            end else begin
                exp_t x;
                x = qb.pop_front();
                cmp("b_data_out", {16'd0, dout_b}, {16'd0, x.d});
                cmp("b_err", {31'd0, err_b}, {31'd0, x.e});
                cmp("b_wait_cycles", lat_b, {24'd0, x.lat});
            end
            lat_b = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b1, 16'h0000, 1'b1, 16'h0000);
        drive(1, 1'b1, 16'h0000, 1'b1, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        // mem_wait stays low during reset even with request high.
        cmp("reset_wait_a", {31'd0, wait_a}, 32'd0);
        cmp("reset_wait_b", {31'd0, wait_b}, 32'd0);
        cmp("reset_dout_a", {16'd0, dout_a}, 32'd0);
        cmp("reset_err_a", {31'd0, err_a}, 32'd0);
        cmp("reset_dout_b", {16'd0, dout_b}, 32'd0);
        drive(0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        drive(1, 1'b0, 16'h0000, 1'b1, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Instance A, three wait states.
        acc(0, 16'h0010, 1'b0, 16'hBEEF, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        acc(0, 16'h0010, 1'b1, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        acc(0, 16'h0020, 1'b0, 16'h5555, 16'h0020, 16'h5555, 16'hBEEF, 1'b0);
        abort_wr(16'h0020, 16'h1234, 2);
        acc(0, 16'h0020, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h5555, 1'b0);
        // Abort in the same cycle the access would complete.
        abort_wr(16'h0020, 16'h9999, 3);
        acc(0, 16'h0020, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h5555, 1'b0);
        acc(0, 16'h0050, 1'b0, 16'h7777, 16'h0050, 16'h7777, 16'h5555, 1'b0);
        // Address and data change during BUSY; the write must land at 0x0040 with 0xCAFE.
        acc(0, 16'h0040, 1'b0, 16'hCAFE, 16'h0050, 16'hDEAD, 16'h5555, 1'b0);
        acc(0, 16'h0040, 1'b1, 16'h0000, 16'h0040, 16'h0000, 16'hCAFE, 1'b0);
        acc(0, 16'h0050, 1'b1, 16'h0000, 16'h0050, 16'h0000, 16'h7777, 1'b0);
`ifdef SAM_MEM_ALIGN_CHECK_EN
        acc(0, 16'h0011, 1'b0, 16'hBAD0, 16'h0011, 16'hBAD0, 16'h7777, 1'b1);
        acc(0, 16'h0010, 1'b1, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        acc(0, 16'h0200, 1'b1, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 1'b1);
        acc(0, 16'h0010, 1'b1, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
`else
        // 0x0211 wraps and drops bit 0, landing on word 0x0010.
        acc(0, 16'h0211, 1'b0, 16'h4321, 16'h0211, 16'h4321, 16'h7777, 1'b0);
        acc(0, 16'h0010, 1'b1, 16'h0000, 16'h0010, 16'h0000, 16'h4321, 1'b0);
        acc(0, 16'h0210, 1'b1, 16'h0000, 16'h0210, 16'h0000, 16'h4321, 1'b0);
`endif
        acc(0, 16'h0030, 1'b0, 16'h1111, 16'h0030, 16'h1111, LAST_RD, 1'b0);

        // Reset during a BUSY write: outputs clear at once and the write is dropped.
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h0030, 1'b0, 16'hAAAA);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("rst_mid_wait_a", {31'd0, wait_a}, 32'd0);
        cmp("rst_mid_dout_a", {16'd0, dout_a}, 32'd0);
        drive(0, 1'b0, 16'h0030, 1'b0, 16'hAAAA);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc(0, 16'h0030, 1'b1, 16'h0000, 16'h0030, 16'h0000, 16'h1111, 1'b0);

        // Instance B, zero wait states, back-to-back with one idle cycle between.
        acc(1, 16'h0000, 1'b0, 16'h0F0F, 16'h0000, 16'h0F0F, 16'h0000, 1'b0);
        acc(1, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 1'b0);
        acc(1, 16'h0002, 1'b0, 16'hA5A5, 16'h0002, 16'hA5A5, 16'h0F0F, 1'b0);
        acc(1, 16'h0002, 1'b1, 16'h0000, 16'h0002, 16'h0000, 16'hA5A5, 1'b0);
        acc(1, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 1'b0);

        repeat (3) @(posedge clk);
        cmp("a_queue_drained", qa.size(), 32'd0);
        cmp("b_queue_drained", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sam_memory_responder.md
# sam_memory_responder

Memory-side responder for the SAM CPU memory interface. It accepts single-word read/write requests from the CPU datapath and holds `mem_wait` high for a programmable number of wait states. It then completes the access against an internal word array and returns read data on a registered output. It is the slave end of the REQUEST/RW/WAIT handshake that the SAM controller issues through MAR/MBR.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 16-bit words; must be a power of two, ≥2.
- `WAIT_CYCLES`, 3: number of BUSY cycles per access; legal range 0–15.

Ports:
- `clk`  in  1  Single clock; all state updates on its rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `address`  in  16  Byte address; word index = `address[log2(DEPTH_WORDS):1]`.
- `request`  in  1  Access request, level; held high by the CPU until `mem_wait` falls.
- `rw`  in  1  1 = read, 0 = write.
- `data_in`  in  16  Write data from the CPU (MBR).
- `data_out`  out  16  Registered read data.
- `mem_wait`  out  1  High while an accepted request is not yet complete.
- `err`  out  1  Access fault flag; see Configuration.

## Operation
- FSM states: IDLE, BUSY, DONE; counter `cnt`, 4 bits.
- **IDLE**
  - `request`=1: latch `address`, `rw`, `data_in`.
    - If `WAIT_CYCLES`>0: go to BUSY with `cnt`=`WAIT_CYCLES`-1.
    - If `WAIT_CYCLES`=0: perform the access and go directly to DONE.
- **BUSY**
  - `request`=0: abort; no write, `data_out` unchanged, go to IDLE.
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: perform the access and go to DONE.
- **Access**
  - Read: `data_out` ← `mem[index]`.
  - Write: `mem[index]` ← latched data; `data_out` unchanged.
- **DONE**
  - Stay while `request`=1; go to IDLE when `request`=0.
  - A new request requires `request` to drop low for at least one cycle.
- `mem_wait` = `request` && (state≠DONE), decoded from registered state. It rises in the same cycle as `request`, so the CPU never sees a false completion.
- Address, `rw` and `data_in` changes after acceptance are ignored; the latched values are used.
- Without the macro, out-of-range addresses wrap modulo `DEPTH_WORDS` and `address[0]` is ignored.

## Timing
- Reset values: `data_out`=0, `err`=0, state=IDLE, `cnt`=0, `mem_wait`=0 (forced while `rst_n`=0). Array contents are not reset.
- Latency: `mem_wait` is high for exactly `WAIT_CYCLES`+1 cycles, counted from the first cycle `request` is high in IDLE.
  - `data_out` and `err` are valid in the first DONE cycle and held until the next completed access.
- Write visibility: a read issued after the write's DONE returns the new data.
- Reset asserted mid-access: immediate return to IDLE; a pending write is dropped and the array is left unmodified.
- Dropping `request` in the same cycle as completion (BUSY, `cnt`=0): abort wins; no write, no `data_out` update.

## Configuration
- Macro: `SAM_MEM_ALIGN_CHECK_EN`.
- **Defined:** at access time, `err` is set when `address[0]`=1 or `address` ≥ 2·`DEPTH_WORDS`.
  - Faulting write: suppressed.
  - Faulting read: sets `data_out`=0.
  - `err` is cleared by the next non-faulting completed access.
  - Handshake timing is unchanged.
- **Not defined:** `err` is tied 0 and wrap/ignore rules apply.

## Test plan
- Write then read, `WAIT_CYCLES`=3:
  - Write 0xBEEF @0x0010: `mem_wait` high 4 cycles, then low.
  - Read 0x0010: `data_out`=0xBEEF in the first DONE cycle.
- `WAIT_CYCLES`=0: read @0x0000 after reset returns the array value with `mem_wait` high exactly 1 cycle. Back-to-back requests separated by 1 low cycle both complete.
- Abort: write 0x1234 @0x0020 with `request` dropped during BUSY.
  - State returns to IDLE.
  - A subsequent read @0x0020 returns the prior value, not 0x1234.
- Reset mid-BUSY write: `rst_n` low for 1 cycle.
  - `mem_wait`=0 and `data_out`=0 immediately.
  - Target word unchanged.
- Latching: change `address` and `data_in` during BUSY. The access uses the values sampled in IDLE.
- With `SAM_MEM_ALIGN_CHECK_EN`, `DEPTH_WORDS`=256:
  - Write @0x0011: `err`=1, memory unchanged.
  - Read @0x0200: `err`=1, `data_out`=0.
  - Next read @0x0010: `err`=0.
  - Without the macro, @0x0210 aliases to @0x0010.
